// File: rtl/micro_sequencer_if.sv
// Sequencing bus between the microinstruction decode stage (master) and the
// micro-sequencer (slave).
interface micro_sequencer_if #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4
);
   localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

   logic              stall;
   logic              status;
   logic [2:0]        seq_op;
   logic [ADDR_W-1:0] branch_addr;
   logic [ADDR_W-1:0] map_addr;
   logic [ADDR_W-1:0] upc;
   logic [DEPTH_W-1:0] stack_depth;
   logic              seq_err;

   modport master (
      output stall, status, seq_op, branch_addr, map_addr,
      input  upc, stack_depth, seq_err
   );

   modport slave (
      input  stall, status, seq_op, branch_addr, map_addr,
      output upc, stack_depth, seq_err
   );
endinterface

// File: rtl/micro_sequencer.sv
// Micro-program counter with a bounded return-address stack, conditional
// branching, opcode mapping and a sticky overflow/underflow error flag.
module micro_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4
) (
   input logic               clk,
   input logic               reset_n,
   micro_sequencer_if.slave  seq
);
   localparam int PTR_W   = $clog2(STACK_DEPTH);
   localparam int DEPTH_W = PTR_W + 1;

   typedef enum logic [2:0] {
      OP_NEXT  = 3'b000,
      OP_JUMP  = 3'b001,
      OP_CJUMP = 3'b010,
      OP_MAP   = 3'b011,
      OP_CALL  = 3'b100,
      OP_CCALL = 3'b101,
      OP_RET   = 3'b110,
      OP_WAIT  = 3'b111
   } seq_op_e;

   seq_op_e            op;
   logic [ADDR_W-1:0]  upc_q, upc_next, upc_inc;
   logic [DEPTH_W-1:0] depth_q, depth_next;
   logic               err_q, err_next;
   logic               push;
   logic [PTR_W-1:0]   push_idx, top_idx;
   logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];

   assign op       = seq_op_e'(seq.seq_op);
   assign upc_inc  = upc_q + ADDR_W'(1);
   assign push_idx = depth_q[PTR_W-1:0];
   assign top_idx  = PTR_W'(depth_q - DEPTH_W'(1));

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      upc_next   = upc_q;
      depth_next = depth_q;
      err_next   = err_q;
      push       = 1'b0;
      case (op)
         OP_NEXT:  upc_next = upc_inc;
         OP_JUMP:  upc_next = seq.branch_addr;
         OP_CJUMP: upc_next = seq.status ? seq.branch_addr : upc_inc;
         OP_MAP:   upc_next = seq.map_addr;
         OP_CALL, OP_CCALL: begin
            if (op == OP_CCALL && !seq.status) begin
               upc_next = upc_inc;
            end else if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
               // Overflow: flag it and hold both upc and the stack.
               err_next = 1'b1;
            end else begin
               push       = 1'b1;
               depth_next = depth_q + DEPTH_W'(1);
               upc_next   = seq.branch_addr;
            end
         end
         OP_RET: begin
            if (depth_q == '0) begin
               err_next = 1'b1;
               upc_next = '0;
            end else begin
               depth_next = depth_q - DEPTH_W'(1);
               upc_next   = stack_mem[top_idx];
            end
         end
         OP_WAIT:  upc_next = seq.status ? upc_inc : upc_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         upc_q   <= '0;
         depth_q <= '0;
         err_q   <= 1'b0;
      end else if (!seq.stall) begin
         upc_q   <= upc_next;
         depth_q <= depth_next;
         err_q   <= err_next;
      end
   end

   // NOTE: stack storage has no reset; entries above the depth count are never read.
   always_ff @(posedge clk) begin
      if (push && !seq.stall) begin
         stack_mem[push_idx] <= upc_inc;
      end
   end

   assign seq.upc         = upc_q;
   assign seq.stack_depth = depth_q;
   assign seq.seq_err     = err_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a queue-based reference model checked
// every cycle, plus hand-computed expectations along the way.
module tb_micro_sequencer;
   localparam int ADDR_W      = 8;
   localparam int STACK_DEPTH = 4;

   localparam logic [2:0] NEXT  = 3'b000;
   localparam logic [2:0] JUMP  = 3'b001;
   localparam logic [2:0] CJUMP = 3'b010;
   localparam logic [2:0] MAP   = 3'b011;
   localparam logic [2:0] CALL  = 3'b100;
   localparam logic [2:0] CCALL = 3'b101;
   localparam logic [2:0] RET   = 3'b110;
   localparam logic [2:0] WAIT  = 3'b111;

   logic clk;
   logic reset_n;

   micro_sequencer_if #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) bus ();

   micro_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .seq     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   // Reference model: return addresses live in a plain queue.
   int m_upc;
   int m_stack[$];
   bit m_err;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_upc = 0;
      m_stack.delete();
      m_err = 1'b0;
   endtask

   task automatic model_update(input logic [2:0] op, input int br, input int map,
                               input bit st, input bit stl);
      int nxt;
      nxt = (m_upc + 1) % 256;
      if (stl) return;
      case (op)
         NEXT:  m_upc = nxt;
         JUMP:  m_upc = br;
         CJUMP: m_upc = st ? br : nxt;
         MAP:   m_upc = map;
         CALL, CCALL: begin
            if (op == CCALL && !st) m_upc = nxt;
            else if (m_stack.size() == STACK_DEPTH) m_err = 1'b1;
            else begin
               m_stack.push_back(nxt);
               m_upc = br;
            end
         end
         RET: begin
            if (m_stack.size() == 0) begin
               m_err = 1'b1;
               m_upc = 0;
            end else m_upc = m_stack.pop_back();
         end
         default: m_upc = st ? nxt : m_upc;
      endcase
   endtask

   // One instruction: drive, clock it in, update the model, settle at negedge.
   task automatic step(input logic [2:0] op, input int br = 0, input bit st = 1'b0,
                       input bit stl = 1'b0, input int map = 0);
      bus.seq_op      = op;
      bus.branch_addr = br[7:0];
      bus.status      = st;
      bus.stall       = stl;
      bus.map_addr    = map[7:0];
      @(posedge clk);
      model_update(op, br, map, st, stl);
      @(negedge clk);
   endtask

   task automatic expect_state(input string name, input int upc, input int depth, input int err);
      check({name, ".upc"},   int'(bus.upc),         upc);
      check({name, ".depth"}, int'(bus.stack_depth), depth);
      check({name, ".err"},   int'(bus.seq_err),     err);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("model.upc",   int'(bus.upc),         m_upc);
         check("model.depth", int'(bus.stack_depth), m_stack.size());
         check("model.err",   int'(bus.seq_err),     int'(m_err));
      end
   end

   initial begin
      reset_n         = 1'b0;
      bus.seq_op      = NEXT;
      bus.branch_addr = '0;
      bus.map_addr    = '0;
      bus.status      = 1'b0;
      bus.stall       = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      expect_state("reset", 0, 0, 0);
      reset_n = 1'b1;
      cmp_en  = 1'b1;

      step(NEXT); check("next1", int'(bus.upc), 1);
      step(NEXT); check("next2", int'(bus.upc), 2);
      step(NEXT); check("next3", int'(bus.upc), 3);
      step(JUMP, 'hFF); check("jump_ff", int'(bus.upc), 'hFF);
      step(NEXT);       check("wrap", int'(bus.upc), 'h00);

      step(JUMP, 'h10); step(CJUMP, 'h40, 1'b0); check("cjump_nt", int'(bus.upc), 'h11);
      step(JUMP, 'h10); step(CJUMP, 'h40, 1'b1); check("cjump_t", int'(bus.upc), 'h40);

      step(JUMP, 'h05);
      step(CALL, 'h80); expect_state("call", 'h80, 1, 0);
      step(RET);        expect_state("ret", 'h06, 0, 0);

      step(JUMP, 'h30);
      step(CALL, 'h40); step(CALL, 'h50); step(CALL, 'h60); step(CALL, 'h70);
      expect_state("nest4", 'h70, 4, 0);
      step(CALL, 'h20); expect_state("overflow", 'h70, 4, 1);
      step(RET); expect_state("pop1", 'h61, 3, 1);
      step(RET); expect_state("pop2", 'h51, 2, 1);
      step(RET); expect_state("pop3", 'h41, 1, 1);
      step(RET); expect_state("pop4", 'h31, 0, 1);
      step(RET); expect_state("underflow", 'h00, 0, 1);

      for (int i = 0; i < 5; i++) begin
         step(WAIT, 0, 1'b0);
         check("wait_hold", int'(bus.upc), 'h00);
      end
      step(WAIT, 0, 1'b1);                   check("wait_go", int'(bus.upc), 'h01);
      step(MAP, 0, 1'b0, 1'b0, 'h9A);        check("map", int'(bus.upc), 'h9A);
      step(CCALL, 'h22, 1'b0);               expect_state("ccall_nt", 'h9B, 0, 1);
      step(CCALL, 'h22, 1'b1);               expect_state("ccall_t", 'h22, 1, 1);
      step(CALL, 'h44, 1'b0, 1'b1);          expect_state("stall_call", 'h22, 1, 1);
      step(RET);                             expect_state("ret_ccall", 'h9C, 0, 1);

      // Asynchronous reset pulse between edges in the middle of a call chain.
      step(CALL, 'h50); step(CALL, 'h60);
      #1 reset_n = 1'b0;
      bus.seq_op = NEXT;
      #1 expect_state("async_rst", 0, 0, 0);
      model_reset();
      #1 reset_n = 1'b1;
      @(posedge clk);
      model_update(NEXT, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("resume", int'(bus.upc), 1);

      step(RET, 0, 1'b0, 1'b1); expect_state("stall_ret", 1, 0, 0);
      step(RET);                expect_state("underflow2", 0, 0, 1);
      step(JUMP, 'h33);         check("err_sticky_jump", int'(bus.upc), 'h33);

      // Reset asserted while stalled in a WAIT still clears state.
      bus.seq_op = WAIT; bus.status = 1'b0; bus.stall = 1'b1;
      #1 reset_n = 1'b0;
      #1 expect_state("rst_stall_wait", 0, 0, 0);
      model_reset();
      #1 reset_n = 1'b1;
      bus.stall = 1'b0;
      @(posedge clk);
      model_update(WAIT, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("wait_after_rst", int'(bus.upc), 0);

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
